// File: rtl/arb_pkg.sv
// Shared constants, FSM state type and index-to-one-hot helper for the 8-way round-robin arbiter.
package arb_pkg;
   localparam int N_REQ = 8;
   localparam int SEL_W = 3;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   function automatic logic [N_REQ-1:0] idx2onehot(input logic [SEL_W-1:0] idx);
      logic [N_REQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction
endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin pick: first set request after ptr, wrapping modulo 8.
// Rotate so ptr+1 lands at bit 0, priority-encode, then add the rotation back.
module rr_pick8
   import arb_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [SEL_W-1:0] ptr,
   output logic [SEL_W-1:0] pick,
   output logic             any_req
);
   logic [SEL_W-1:0]   w_shift;
   logic [2*N_REQ-1:0] w_dbl;
   logic [N_REQ-1:0]   w_rot;
   logic [SEL_W-1:0]   w_enc;

   assign w_shift = ptr + 3'd1;
   assign w_dbl   = {req, req};
   assign w_rot   = w_dbl[w_shift +: N_REQ];
   assign any_req = |req;

   always_comb begin
      w_enc = '0;
      for (int j = N_REQ - 1; j >= 0; j--) begin
         if (w_rot[j]) w_enc = SEL_W'(j);
      end
   end

   assign pick = w_shift + w_enc;
endmodule

// File: rtl/rr_arbiter8.sv
// 8-way round-robin grant/hold arbiter driving an 8:1 mux select; grant appears one cycle after request in IDLE.
// Grant held until rel or owner drops req, then one idle cycle; ARB_TIMEOUT_EN adds MAX_HOLD revocation with preempt pulse.
module rr_arbiter8
   import arb_pkg::*;
#(
   parameter int MAX_HOLD = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_REQ-1:0] req,
   input  logic             rel,
   output logic [N_REQ-1:0] grant,
   output logic [SEL_W-1:0] sel,
   output logic             busy,
   output logic             preempt
);
   if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
      $error("rr_arbiter8: MAX_HOLD out of range 2..255");
   end

   state_t           r_state, w_state_nxt;
   logic [N_REQ-1:0] r_grant, w_grant_nxt;
   logic [SEL_W-1:0] r_sel, w_sel_nxt;
   logic [SEL_W-1:0] r_ptr, w_ptr_nxt;
   logic             r_busy, w_busy_nxt;
   logic [SEL_W-1:0] w_pick;
   logic             w_any;
   logic             w_release;

   rr_pick8 u_pick (
      .req     (req),
      .ptr     (r_ptr),
      .pick    (w_pick),
      .any_req (w_any)
   );

   assign w_release = rel | ~req[r_ptr];

`ifdef ARB_TIMEOUT_EN
   logic [7:0] r_cnt, w_cnt_nxt;
   logic       r_preempt, w_preempt_nxt;
   logic       w_expired;

   assign w_expired = (r_cnt == 8'(MAX_HOLD - 1));
   assign preempt   = r_preempt;
`else
   assign preempt = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant;
      w_sel_nxt   = r_sel;
      w_ptr_nxt   = r_ptr;
      w_busy_nxt  = r_busy;
`ifdef ARB_TIMEOUT_EN
      w_cnt_nxt     = 8'd0;
      w_preempt_nxt = 1'b0;
`endif
      case (r_state)
         IDLE: begin
            if (w_any) begin
               w_state_nxt = GRANT;
               w_grant_nxt = idx2onehot(w_pick);
               w_sel_nxt   = w_pick;
               w_ptr_nxt   = w_pick;
               w_busy_nxt  = 1'b1;
            end
         end
         GRANT: begin
            if (w_release) begin
               w_state_nxt = IDLE;
               w_grant_nxt = '0;
               w_busy_nxt  = 1'b0;
            end
`ifdef ARB_TIMEOUT_EN
            // ptr stays on the revoked owner so it goes to the back of the queue
            else if (w_expired) begin
               w_state_nxt   = IDLE;
               w_grant_nxt   = '0;
               w_busy_nxt    = 1'b0;
               w_preempt_nxt = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + 8'd1;
            end
`endif
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_grant <= '0;
         r_sel   <= '0;
         r_ptr   <= 3'd7;
         r_busy  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
         r_cnt     <= 8'd0;
         r_preempt <= 1'b0;
`endif
      end else begin
         r_state <= w_state_nxt;
         r_grant <= w_grant_nxt;
         r_sel   <= w_sel_nxt;
         r_ptr   <= w_ptr_nxt;
         r_busy  <= w_busy_nxt;
`ifdef ARB_TIMEOUT_EN
         r_cnt     <= w_cnt_nxt;
         r_preempt <= w_preempt_nxt;
`endif
      end
   end

   assign grant = r_grant;
   assign sel   = r_sel;
   assign busy  = r_busy;
endmodule
